instr_packer: RTL and testbench
===============================

Name: instr_packer

Overview:
- Inverse of the instruction field splitter: takes decoded MIPS fields (format, opcode, rs, rt, rd, shamt s, funct, imm16, imm26) and packs them into 32-bit instruction words.
- Writes the packed words sequentially into the instruction-memory write port, starting at a programmable word index.
- Used by the test loader and the self-check path to build IM images inside the P5 pipeline environment.
- Valid/ready on the input side, one-entry output register with backpressure from IM, and a run FSM with done/error reporting.

Parameters:
- ADDR_W, 10, IM word-index width; IM depth is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- base_idx  in  ADDR_W  first IM word index of the run, latched on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid&&in_ready
- in_fmt  in  2  0=R, 1=I, 2=J, 3=reserved
- in_op  in  6  opcode
- in_rs, in_rt, in_rd, in_s  in  5 each  register and shamt fields
- in_funct  in  6  funct field
- in_imm16  in  16  I-type immediate
- in_imm26  in  26  J-type target
- in_last  in  1  marks the final bundle of the run
- we  out  1  IM write strobe, held until wready
- waddr  out  ADDR_W  IM word index
- wdata  out  32  packed instruction
- wready  in  1  IM accepts the write when we&&wready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at run end
- count  out  ADDR_W+1  words written this run; saturates at 2^ADDR_W
- err  out  2  sticky; [0] reserved format seen, [1] address wrapped

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; we=0, waddr=0, wdata=0, done=0, count=0, err=0, in_ready=0, internal last flag=0, next-address register=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start, nxt_addr<=base_idx, count<=0, err<=0, go to RUN.
  - RUN: packs and writes bundles. When the output handshake (we&&wready) occurs for a word tagged last, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored outside IDLE.
- in_ready = (state==RUN) && (!we || wready) && !(we && out_last). Once the last bundle is accepted, no further bundles are taken.
- Acceptance: on in_valid&&in_ready, register the following on the next edge:
  - wdata=pack(fields), waddr=nxt_addr, out_last=in_last, we=1;
  - nxt_addr<=nxt_addr+1, modulo 2^ADDR_W.
  - Latency is 1 cycle from acceptance to we. Throughput is 1 word/cycle while wready=1.
- Output hold: we, waddr and wdata stay stable until wready. we falls on the handshake edge unless a new bundle is accepted on that same edge (back-to-back case).
- Packing:
  - R: {op,rs,rt,rd,s,funct}
  - I: {op,rs,rt,imm16}
  - J: {op,imm26}
  - fmt=3: wdata=32'h0 (nop) and err[0] set on acceptance.
  - Unused fields are ignored.
- count increments on each output handshake and saturates at 2^ADDR_W.
- err[1] is set when the accepted address is 2^ADDR_W-1 and a further bundle is accepted afterwards (the index wrapped). The write still proceeds to the wrapped index.
- Simultaneous output handshake and new acceptance: both take effect on the same edge; count+1 and the new word is presented.
- wready asserted while we=0 has no effect.
- Reset mid-run: immediate return to IDLE. A pending write is dropped (we=0 asynchronously).

Decomposition:
- Package instr_pkg:
  - FMT_R/FMT_I/FMT_J/FMT_RSV constants
  - state enum {IDLE,RUN,DONE}
  - field slice constants (OP_MSB=31, RS=25:21, RT=20:16, RD=15:11, S=10:6, FUNCT=5:0), shared with the splitter.
- One combinational sub-module, instr_field_pack (fields+fmt -> word, reserved flag), reusable by the bench as its reference model.

Test Plan:
1. start with base_idx=0x000; three bundles: R addu (op0,rs1,rt2,rd3,s0,funct 0x21); I ori (op 0x0D,rs0,rt1,imm 0x1234); J j (op 0x02,imm26 0x0000C00) last; wready=1 → writes 0x00221821@0, 0x34011234@1, 0x08000C00@2 on consecutive cycles; done pulses once; count=3; err=0.
2. Same stream with wready low for 3 cycles on word 1 → we/waddr=1/wdata=0x34011234 held stable; in_ready=0 during the stall; no word lost or duplicated; count=3.
3. fmt=3 bundle at base_idx=0x010 → wdata=0x00000000@0x010; err=2'b01 and it stays set until the next start.
4. base_idx=0x3FE, 3 words → addresses 0x3FE, 0x3FF, 0x000; err[1]=1.
5. Assert reset while we=1 in RUN → we=0, busy=0 immediately; a following start with base 5 writes its first word at 5 with count=1.
6. start asserted during RUN and in DONE → ignored; base_idx is not re-latched and count is unaffected.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared MIPS field definitions for the instruction packer and splitter.
// Slice positions are the single source of truth for both directions.
package instr_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_RSV = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int S_MSB     = 10;
  localparam int S_LSB     = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM16_MSB = 15;
  localparam int IMM26_MSB = 25;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  s;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;
  } fields_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field-to-word packer; reserved format yields a nop word
// and raises rsv so the caller can flag it.
module instr_field_pack
  import instr_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        rsv
);

  always_comb begin
    word = '0;
    rsv  = 1'b0;
    case (f.fmt)
      FMT_R: begin
        word[OP_MSB:OP_LSB]       = f.op;
        word[RS_MSB:RS_LSB]       = f.rs;
        word[RT_MSB:RT_LSB]       = f.rt;
        word[RD_MSB:RD_LSB]       = f.rd;
        word[S_MSB:S_LSB]         = f.s;
        word[FUNCT_MSB:FUNCT_LSB] = f.funct;
      end
      FMT_I: begin
        word[OP_MSB:OP_LSB] = f.op;
        word[RS_MSB:RS_LSB] = f.rs;
        word[RT_MSB:RT_LSB] = f.rt;
        word[IMM16_MSB:0]   = f.imm16;
      end
      FMT_J: begin
        word[OP_MSB:OP_LSB] = f.op;
        word[IMM26_MSB:0]   = f.imm26;
      end
      FMT_RSV: rsv = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Packs decoded MIPS fields into words and streams them into the IM write
// port from a programmable base index, with a one-entry output register.
module instr_packer
  import instr_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_idx,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_s,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm16,
  input  logic [25:0]       in_imm26,
  input  logic              in_last,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  input  logic              wready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        err
);

  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  fields_t           fld;
  logic [31:0]       pack_word;
  logic              pack_rsv;
  logic [ADDR_W-1:0] nxt_addr;
  logic              out_last;
  logic              at_top;
  logic              accept;
  logic              wr_hs;

  assign fld = '{fmt: in_fmt, op: in_op, rs: in_rs, rt: in_rt, rd: in_rd,
                 s: in_s, funct: in_funct, imm16: in_imm16, imm26: in_imm26};

  instr_field_pack u_pack (
    .f    (fld),
    .word (pack_word),
    .rsv  (pack_rsv)
  );

  assign wr_hs  = we && wready;
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Input stalls while the output slot is occupied and not draining, and
  // closes for good once the last word of the run sits in the slot.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        in_ready = (!we || wready) && !(we && out_last);
        if (wr_hs && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      out_last <= 1'b0;
      nxt_addr <= '0;
      count    <= '0;
      err      <= '0;
      at_top   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        nxt_addr <= base_idx;
        count    <= '0;
        err      <= '0;
        at_top   <= 1'b0;
        out_last <= 1'b0;
      end
      if (wr_hs) begin
        we <= 1'b0;
        if (count != CNT_MAX) count <= count + CNT_ONE;
      end
      // A same-edge accept overrides the we clear above (back-to-back).
      if (accept) begin
        we       <= 1'b1;
        waddr    <= nxt_addr;
        wdata    <= pack_word;
        out_last <= in_last;
        nxt_addr <= nxt_addr + ADR_ONE;
        at_top   <= &nxt_addr;
        if (pack_rsv) err[0] <= 1'b1;
        if (at_top)   err[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: hand-computed words, addresses and
// status checked through a single comparison task.
module tb_instr_packer;
  import instr_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_idx = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_fmt = '0;
  logic [5:0]    in_op = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_s = '0;
  logic [5:0]    in_funct = '0;
  logic [15:0]   in_imm16 = '0;
  logic [25:0]   in_imm26 = '0;
  logic          in_last = 1'b0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          wready = 1'b1;
  logic          busy, done;
  logic [AW:0]   count;
  logic [1:0]    err;

  always #5 clk = ~clk;

  instr_packer #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_idx(base_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_s(in_s),
    .in_funct(in_funct), .in_imm16(in_imm16), .in_imm26(in_imm26),
    .in_last(in_last), .we(we), .waddr(waddr), .wdata(wdata), .wready(wready),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0;
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int            log_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor, sampled mid-cycle so the handshake seen here is the
  // one taken on the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (we && wready) begin
      log_addr.push_back(waddr);
      log_data.push_back(wdata);
      log_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic chk_word(input string tag, input int i, input logic [AW-1:0] a, input logic [31:0] d);
    logic [AW-1:0] oa;
    logic [31:0]   od;
    oa = (i < log_addr.size()) ? log_addr[i] : 'x;
    od = (i < log_data.size()) ? log_data[i] : 'x;
    chk({tag, "_addr"}, 64'(oa), 64'(a));
    chk({tag, "_data"}, 64'(od), 64'(d));
  endtask

  task automatic start_run(input logic [AW-1:0] b);
    @(posedge clk); #1;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    done_cnt = 0;
    start = 1'b1; base_idx = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] s,
                      input logic [5:0] fn, input logic [15:0] i16, input logic [25:0] i26,
                      input logic last);
    bit ok = 0;
    in_fmt = f; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_s = s;
    in_funct = fn; in_imm16 = i16; in_imm26 = i26; in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept_in_time", 64'(ok), 64'(1));
  endtask

  // Unused fields carry junk so packing must ignore them.
  task automatic send_addu(input logic last);
    send(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hFFFF, 26'h3FFFFFF, last);
  endtask
  task automatic send_ori(input logic last);
    send(FMT_I, 6'h0D, 5'd0, 5'd1, 5'h1F, 5'h1F, 6'h3F, 16'h1234, 26'h3FFFFFF, last);
  endtask
  task automatic send_j(input logic last);
    send(FMT_J, 6'h02, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h0000C00, last);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_waddr", 64'(waddr), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1; reset = 1'b1;

    // 1: three-word stream at full throughput
    start_run(10'h000);
    send_addu(0); send_ori(0); send_j(1);
    wait_done("t1");
    chk("t1_count", 64'(count), 64'(3));
    chk("t1_err", 64'(err), 64'(0));
    repeat (2) @(negedge clk);
    chk("t1_busy_after", 64'(busy), 64'(0));
    chk("t1_done_pulses", 64'(done_cnt), 64'(1));
    chk("t1_nwords", 64'(log_addr.size()), 64'(3));
    chk_word("t1_w0", 0, 10'h000, 32'h00221821);
    chk_word("t1_w1", 1, 10'h001, 32'h34011234);
    chk_word("t1_w2", 2, 10'h002, 32'h08000C00);
    if (log_cyc.size() == 3) begin
      chk("t1_gap01", 64'(log_cyc[1] - log_cyc[0]), 64'(1));
      chk("t1_gap12", 64'(log_cyc[2] - log_cyc[1]), 64'(1));
    end else chk("t1_cyc_log", 64'(log_cyc.size()), 64'(3));

    // 2: three-cycle IM stall on word 1
    start_run(10'h000);
    fork
      begin send_addu(0); send_ori(0); send_j(1); end
      begin
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
          @(posedge clk); #1;
          if (we && waddr == 10'h001) found = 1;
        end
        chk("t2_word1_seen", 64'(found), 64'(1));
        wready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("t2_hold_we", 64'(we), 64'(1));
          chk("t2_hold_waddr", 64'(waddr), 64'(1));
          chk("t2_hold_wdata", 64'(wdata), 64'h34011234);
          chk("t2_in_ready", 64'(in_ready), 64'(0));
          @(posedge clk); #1;
        end
        wready = 1'b1;
      end
    join
    wait_done("t2");
    chk("t2_count", 64'(count), 64'(3));
    chk("t2_nwords", 64'(log_addr.size()), 64'(3));
    chk_word("t2_w0", 0, 10'h000, 32'h00221821);
    chk_word("t2_w1", 1, 10'h001, 32'h34011234);
    chk_word("t2_w2", 2, 10'h002, 32'h08000C00);

    // 3: reserved format -> nop word, sticky err[0]
    start_run(10'h010);
    send(FMT_RSV, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b1);
    wait_done("t3");
    chk("t3_err", 64'(err), 64'(2'b01));
    chk("t3_nwords", 64'(log_addr.size()), 64'(1));
    chk_word("t3_w0", 0, 10'h010, 32'h00000000);
    repeat (3) @(negedge clk);
    chk("t3_err_sticky", 64'(err), 64'(2'b01));

    // 4: index wrap past the top of IM
    start_run(10'h3FE);
    send_addu(0); send_ori(0); send_j(1);
    wait_done("t4");
    chk("t4_err", 64'(err), 64'(2'b10));
    chk("t4_count", 64'(count), 64'(3));
    chk_word("t4_w0", 0, 10'h3FE, 32'h00221821);
    chk_word("t4_w1", 1, 10'h3FF, 32'h34011234);
    chk_word("t4_w2", 2, 10'h000, 32'h08000C00);

    // 5: asynchronous reset with a write pending, then a clean run
    start_run(10'h100);
    send_addu(0);
    chk("t5_we_pending", 64'(we), 64'(1));
    reset = 1'b0;
    #1;
    chk("t5_rst_we", 64'(we), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_in_ready", 64'(in_ready), 64'(0));
    chk("t5_rst_count", 64'(count), 64'(0));
    @(posedge clk); #1; reset = 1'b1;
    start_run(10'h005);
    send_j(1);
    wait_done("t5");
    chk("t5_count", 64'(count), 64'(1));
    chk("t5_nwords", 64'(log_addr.size()), 64'(1));
    chk_word("t5_w0", 0, 10'h005, 32'h08000C00);

    // 6: start pulses in RUN and DONE are ignored
    start_run(10'h020);
    send_addu(0);
    @(posedge clk); #1; start = 1'b1; base_idx = 10'h200;
    @(posedge clk); #1; start = 1'b0;
    send_ori(1);
    wait_done("t6");
    start = 1'b1; base_idx = 10'h300;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_count", 64'(count), 64'(2));
    chk_word("t6_w0", 0, 10'h020, 32'h00221821);
    chk_word("t6_w1", 1, 10'h021, 32'h34011234);
    repeat (2) @(negedge clk);
    chk("t6_still_idle", 64'(busy), 64'(0));
    chk("t6_done_pulses", 64'(done_cnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
